seq_frame_generator: RTL and testbench

- Serial 4-bit frame transmitter; the sending end of the team's Mealy sequence detector link.
- Accepts 4-bit frames over a valid/ready handshake and shifts them out MSB-first, one bit per clk, with no gaps.
- Inserts a fill frame whenever no data is queued, so 4-bit frame alignment with the detector is never lost.
- Produces exp_dec, cycle-aligned with the detector's dec output, which the bench uses as a scoreboard.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_hold_buf.sv | 54 +++++
 rtl/seq_frame_generator.sv | 108 ++++++++++
 tb/tb_seq_frame_generator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame link: match patterns, frame length,
// default fill value, phase encoding and the pattern match helper.
package seq_pkg;

    localparam logic [3:0] PAT_1110     = 4'b1110;
    localparam logic [3:0] PAT_1001     = 4'b1001;
    localparam logic [3:0] PAT_0111     = 4'b0111;
    localparam int         FRAME_LEN    = 4;
    localparam logic [3:0] FILL_DEFAULT = 4'b0000;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    function automatic logic is_match(input logic [3:0] frame);
        return (frame == PAT_1110) || (frame == PAT_1001) || (frame == PAT_0111);
    endfunction

endpackage

// File: rtl/seq_hold_buf.sv
// Single-entry valid/ready holding register with a bypass path.
// load_i marks the cycle the consumer takes a frame; on that cycle a stored
// frame drains and may be refilled in the same edge, or an incoming frame
// passes straight through when nothing is stored.
module seq_hold_buf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         accept;

    assign in_ready_o  = !full_q || load_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = full_q || in_valid_i;
    assign out_data_o  = full_q ? data_q : in_data_i;

    // Next-state for the stored entry: drain/refill on load, capture otherwise.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            // Empty + accept is a bypass, so the entry only stays full on a refill.
            full_d = full_q && accept;
            if (full_q && accept) begin
                data_d = in_data_i;
            end
        end else if (accept) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    // Entry register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/seq_frame_generator.sv
// Serial 4-bit frame transmitter feeding the Mealy sequence detector.
// Frames go out MSB-first with no gaps; a fill frame keeps alignment when
// nothing is queued. exp_dec mirrors the detector's dec output cycle by cycle.
//
// state | meaning
// P0    | out carries bit 3 of the current frame (frame_start)
// P1    | out carries bit 2
// P2    | out carries bit 1
// P3    | out carries bit 0; next frame loads on this edge, counters update
module seq_frame_generator
    import seq_pkg::*;
#(
    parameter logic [3:0] FILL  = FILL_DEFAULT,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out,
    output logic             frame_start,
    output logic             exp_dec,
    output logic             fill_sent,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] match_cnt
);

    phase_e           phase_q, phase_d;
    logic [3:0]       shreg_q, shreg_d;
    logic             fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             load;
    logic             hb_valid;
    logic [3:0]       hb_data;
    logic [3:0]       next_frame;

    assign load = (phase_q == P3);

    seq_hold_buf #(.W(4)) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (hb_valid),
        .out_data_o  (hb_data)
    );

    assign out         = shreg_q[3];
    assign frame_start = (phase_q == P0);
    assign exp_dec     = load && match_q;
    assign fill_sent   = fill_q;
    assign frame_cnt   = fcnt_q;
    assign match_cnt   = mcnt_q;

    // Phase sequencing plus shift/load and counter next-state.
    always_comb begin
        phase_d    = phase_q;
        shreg_d    = {shreg_q[2:0], 1'b0};
        fill_d     = fill_q;
        match_d    = match_q;
        fcnt_d     = fcnt_q;
        mcnt_d     = mcnt_q;
        next_frame = FILL;
        case (phase_q)
            P0:      phase_d = P1;
            P1:      phase_d = P2;
            P2:      phase_d = P3;
            default: phase_d = P0;
        endcase
        if (load) begin
            // The hold/bypass mux already gives stored data priority over in_data.
            next_frame = hb_valid ? hb_data : FILL;
            shreg_d    = next_frame;
            fill_d     = !hb_valid;
            match_d    = is_match(next_frame);
            fcnt_d     = fcnt_q + CNT_W'(1);
            if (match_q) begin
                mcnt_d = mcnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset restarts a fill frame at P0 so the first
    // released cycle lines up with a detector released on the same rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= P0;
            shreg_q <= FILL;
            fill_q  <= 1'b1;
            match_q <= is_match(FILL);
            fcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            fcnt_q  <= fcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_seq_frame_generator.sv
// Self-checking bench for seq_frame_generator: directed scenarios plus a long
// randomized run against a queue-based frame model and a serial detector model.
module tb_seq_frame_generator;

    localparam logic [3:0] FILL = seq_pkg::FILL_DEFAULT;
    localparam int         FL   = seq_pkg::FRAME_LEN;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out;
    logic       frame_start;
    logic       exp_dec;
    logic       fill_sent;
    logic [7:0] frame_cnt;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;

    seq_frame_generator #(.FILL(FILL), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out         (out),
        .frame_start (frame_start),
        .exp_dec     (exp_dec),
        .fill_sent   (fill_sent),
        .frame_cnt   (frame_cnt),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    // Frame-level model: cycle index within the run, frame on the wire,
    // queue of accepted-but-not-yet-sent frames, and completion counters.
    int unsigned cyc;
    logic [3:0]  m_cur;
    logic        m_fill;
    logic [3:0]  pend[$];
    logic [7:0]  m_fcnt;
    logic [7:0]  m_mcnt;

    function automatic bit tb_match(input logic [3:0] f);
        case (f)
            4'b1110, 4'b1001, 4'b0111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function int ph();
        return int'(cyc % FL);
    endfunction

    function logic e_out();
        return m_cur[FL - 1 - ph()];
    endfunction

    function logic e_rdy();
        return (pend.size() == 0) || (ph() == FL - 1);
    endfunction

    function logic e_dec();
        return (ph() == FL - 1) && tb_match(m_cur);
    endfunction

    task automatic model_reset();
        cyc    = 0;
        m_cur  = FILL;
        m_fill = 1'b1;
        pend.delete();
        m_fcnt = 8'd0;
        m_mcnt = 8'd0;
    endtask

    // Apply one cycle of inputs, advance the model across the coming edge,
    // and return at the following falling edge for sampling.
    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        if (!r) begin
            model_reset();
        end else begin
            if (v && e_rdy()) pend.push_back(d);
            if (ph() == FL - 1) begin
                m_fcnt++;
                if (tb_match(m_cur)) m_mcnt++;
                if (pend.size() > 0) begin
                    m_cur  = pend.pop_front();
                    m_fill = 1'b0;
                end else begin
                    m_cur  = FILL;
                    m_fill = 1'b1;
                end
            end
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out !== 1'b0) begin errors++; $display("FAIL reset_out cyc=%0d got=%b exp=0", i, out); end
            checks++;
            if (frame_start !== (i % 4 == 0)) begin errors++; $display("FAIL reset_fs cyc=%0d got=%b exp=%b", i, frame_start, (i % 4 == 0)); end
            checks++;
            if (fill_sent !== 1'b1) begin errors++; $display("FAIL reset_fill cyc=%0d got=%b exp=1", i, fill_sent); end
            checks++;
            if (exp_dec !== 1'b0) begin errors++; $display("FAIL reset_dec cyc=%0d got=%b exp=0", i, exp_dec); end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy cyc=%0d got=%b exp=1", i, in_ready); end
            if (i == 0) begin
                checks++;
                if (frame_cnt !== 8'd0 || match_cnt !== 8'd0) begin
                    errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", frame_cnt, match_cnt);
                end
            end
            drive(1'b0, 4'd0, 1'b1);
        end
        checks++;
        if (frame_cnt !== 8'd3) begin errors++; $display("FAIL reset_fcnt got=%0d exp=3", frame_cnt); end
        checks++;
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_mcnt got=%0d exp=0", match_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  q[$];
        logic [15:0] bits;
        logic [7:0]  fc0;
        int          ndec;
        q = '{4'b1110, 4'b1001, 4'b0111, 4'b0110};
        bits = '0;
        fc0  = '0;
        ndec = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (in_ready !== e_rdy()) begin errors++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", i, in_ready, e_rdy()); end
            if (i == 4) fc0 = frame_cnt;
            if (i >= 4) begin
                bits = {bits[14:0], out};
                if (exp_dec === 1'b1) begin
                    ndec++;
                    checks++;
                    if ((i % 4) != 3 || i >= 16) begin errors++; $display("FAIL b2b_dec_pos cyc=%0d got=1 exp=0", i); end
                end
            end
            if (q.size() > 0) begin
                logic [3:0] d;
                d = q[0];
                if (e_rdy()) void'(q.pop_front());
                drive(1'b1, d, 1'b1);
            end else begin
                drive(1'b0, 4'd0, 1'b1);
            end
        end
        checks++;
        if (bits !== 16'b1110_1001_0111_0110) begin errors++; $display("FAIL b2b_stream got=%b exp=1110100101110110", bits); end
        checks++;
        if (ndec != 3) begin errors++; $display("FAIL b2b_ndec got=%0d exp=3", ndec); end
        checks++;
        if (match_cnt !== 8'd3) begin errors++; $display("FAIL b2b_mcnt got=%0d exp=3", match_cnt); end
        checks++;
        if (8'(frame_cnt - fc0) !== 8'd4) begin errors++; $display("FAIL b2b_fcnt got=%0d exp=4", 8'(frame_cnt - fc0)); end
    endtask

    task automatic test_saturate();
        logic [3:0] acc[$];
        logic [3:0] fr;
        int         nrdy;
        nrdy = 0;
        fr   = '0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] d;
            checks++;
            if (in_ready !== e_rdy()) begin errors++; $display("FAIL sat_rdy cyc=%0d got=%b exp=%b", i, in_ready, e_rdy()); end
            checks++;
            if (out !== e_out()) begin errors++; $display("FAIL sat_out cyc=%0d got=%b exp=%b", i, out, e_out()); end
            if (i >= 4 && in_ready === 1'b1) nrdy++;
            fr = {fr[2:0], out};
            if (i % 4 == 3 && fill_sent === 1'b0) begin
                checks++;
                if (acc.size() == 0) begin
                    errors++; $display("FAIL sat_order cyc=%0d got=%b exp=none", i, fr);
                end else begin
                    logic [3:0] a;
                    a = acc.pop_front();
                    if (fr !== a) begin errors++; $display("FAIL sat_order cyc=%0d got=%b exp=%b", i, fr, a); end
                end
            end
            d = 4'($urandom_range(0, 15));
            if (in_ready === 1'b1) acc.push_back(d);
            drive(1'b1, d, 1'b1);
        end
        checks++;
        if (nrdy != 9) begin errors++; $display("FAIL sat_nrdy got=%0d exp=9", nrdy); end
    endtask

    task automatic test_single();
        logic [3:0] f;
        f = 4'b0111;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic eo, ef, ed;
            ef = !(i >= 4 && i < 8);
            eo = ef ? 1'b0 : f[7 - i];
            ed = (i == 7);
            checks++;
            if (out !== eo) begin errors++; $display("FAIL single_out cyc=%0d got=%b exp=%b", i, out, eo); end
            checks++;
            if (fill_sent !== ef) begin errors++; $display("FAIL single_fill cyc=%0d got=%b exp=%b", i, fill_sent, ef); end
            checks++;
            if (exp_dec !== ed) begin errors++; $display("FAIL single_dec cyc=%0d got=%b exp=%b", i, exp_dec, ed); end
            if (i == 2) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL single_rdy got=%b exp=1", in_ready); end
            end
            drive(i == 2, (i == 2) ? f : 4'($urandom_range(0, 15)), 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 4'b1110, 1'b1);
        for (int i = 1; i < 4; i++) drive(1'b0, 4'd0, 1'b1);
        checks++;
        if (out !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL mid_p0 got=%b/%b exp=1/1", out, frame_start); end
        drive(1'b1, 4'b1001, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_hold_full got=%b exp=0", in_ready); end
        drive(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out !== 1'b0 || fill_sent !== 1'b1 || exp_dec !== 1'b0) begin
                errors++; $display("FAIL mid_after cyc=%0d got=out%b fill%b dec%b exp=out0 fill1 dec0", i, out, fill_sent, exp_dec);
            end
            if (i == 0) begin
                checks++;
                if (frame_cnt !== 8'd0 || match_cnt !== 8'd0 || frame_start !== 1'b1) begin
                    errors++; $display("FAIL mid_reset_state got=%0d/%0d/%b exp=0/0/1", frame_cnt, match_cnt, frame_start);
                end
            end
            drive(1'b0, 4'd0, 1'b1);
        end
        checks++;
        if (frame_cnt !== 8'd3 || match_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got=%0d/%0d exp=3/0", frame_cnt, match_cnt); end
    endtask

    task automatic test_random();
        logic [2:0] det_sr;
        int         det_pos;
        logic [7:0] det_mcnt;
        int         rst_at;
        det_sr   = '0;
        det_pos  = 0;
        det_mcnt = '0;
        rst_at   = int'($urandom_range(1500, 2500));
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic v, r, ddec;
            logic [3:0] d;
            checks++;
            if (out !== e_out()) begin errors++; if (errors < 20) $display("FAIL rnd_out n=%0d got=%b exp=%b", n, out, e_out()); end
            checks++;
            if (frame_start !== (ph() == 0)) begin errors++; if (errors < 20) $display("FAIL rnd_fs n=%0d got=%b exp=%b", n, frame_start, (ph() == 0)); end
            checks++;
            if (exp_dec !== e_dec()) begin errors++; if (errors < 20) $display("FAIL rnd_dec n=%0d got=%b exp=%b", n, exp_dec, e_dec()); end
            checks++;
            if (fill_sent !== m_fill) begin errors++; if (errors < 20) $display("FAIL rnd_fill n=%0d got=%b exp=%b", n, fill_sent, m_fill); end
            checks++;
            if (in_ready !== e_rdy()) begin errors++; if (errors < 20) $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, in_ready, e_rdy()); end
            checks++;
            if (frame_cnt !== m_fcnt || match_cnt !== m_mcnt) begin
                errors++; if (errors < 20) $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, frame_cnt, match_cnt, m_fcnt, m_mcnt);
            end
            // Serial detector view: frame alignment from frame_start, decision on the 4th bit.
            if (frame_start === 1'b1) det_pos = 0;
            ddec = (det_pos == FL - 1) && tb_match({det_sr, out});
            checks++;
            if (exp_dec !== ddec) begin errors++; if (errors < 20) $display("FAIL rnd_det n=%0d got=%b exp=%b", n, exp_dec, ddec); end
            checks++;
            if (match_cnt !== det_mcnt) begin errors++; if (errors < 20) $display("FAIL rnd_det_cnt n=%0d got=%0d exp=%0d", n, match_cnt, det_mcnt); end
            if (ddec) det_mcnt++;
            det_sr = {det_sr[1:0], out};
            det_pos++;
            v = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            r = (n != rst_at);
            if (!r) begin
                det_mcnt = '0;
                det_pos  = 0;
            end
            drive(v, d, r);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_saturate();
        test_single();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
